// File: rtl/ysyx_23060191_lsu.sv
// ysyx_23060191_lsu: load/store unit between the ALU and write-back; one word-aligned
// memory transaction per instruction, with lane steering and load extension.
module ysyx_23060191_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wstrb,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [2:0] f3_q, f3_d;
  logic st_q, st_d, mis_q, mis_d;
  logic in_mem, in_mis;
  logic [15:0] sh;
  logic [XLEN-1:0] ld, wd;
  logic [3:0] ws;
  // funct3[1:0] selects size: 00 byte, 01 half, anything else a word
  assign in_mem = in_is_load | in_is_store;
  assign in_mis = in_mem & (in_funct3[1:0] == 2'b01 ? in_alu_result[0] :
                            in_funct3[1:0] != 2'b00 && in_alu_result[1:0] != 2'b00);
  assign sh = 16'(mem_resp_rdata >> {addr_q[1:0], 3'b000});
  always_comb begin
    ld = f3_q[1:0] == 2'b00 ? {{(XLEN-8){~f3_q[2] & sh[7]}}, sh[7:0]} :
         f3_q[1:0] == 2'b01 ? {{(XLEN-16){~f3_q[2] & sh[15]}}, sh} : mem_resp_rdata;
    wd = f3_q[1:0] == 2'b00 ? {(XLEN/8){wdata_q[7:0]}} :
         f3_q[1:0] == 2'b01 ? {(XLEN/16){wdata_q[15:0]}} : wdata_q;
    ws = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
         f3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
  end
  assign in_ready      = state_q == IDLE;
  assign mem_req_valid = state_q == REQ;
  assign mem_req_wen   = mem_req_valid & st_q;
  assign mem_req_addr  = mem_req_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_req_wdata = mem_req_wen ? wd : '0;
  assign mem_req_wstrb = mem_req_wen ? ws : '0;
  assign out_valid     = state_q == DONE;
  assign out_data      = out_valid ? data_q : '0;
  assign out_misalign  = out_valid & mis_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    st_d    = st_q;
    mis_d   = mis_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        addr_d  = in_alu_result;
        wdata_d = in_wdata;
        f3_d    = in_funct3;
        st_d    = in_is_store & ~in_is_load;
        mis_d   = in_mis;
        data_d  = in_mem ? '0 : in_alu_result;
        state_d = in_mem & ~in_mis ? REQ : DONE;
      end
      REQ: if (mem_req_ready) begin
        state_d = mem_resp_valid ? DONE : WAIT;
        data_d  = mem_resp_valid & ~st_q ? ld : '0;
      end
      WAIT: if (mem_resp_valid) begin
        state_d = DONE;
        data_d  = st_q ? '0 : ld;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      mis_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      st_q    <= st_d;
      mis_q   <= mis_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060191_lsu.sv
// tb_ysyx_23060191_lsu: directed bench with a size/offset arithmetic model of the LSU,
// a per-cycle compare process, and literal pins for the worked examples.
module tb_ysyx_23060191_lsu;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_is_load = 0, in_is_store = 0;
  logic [31:0] in_alu_result = 0, in_wdata = 0;
  logic [2:0] in_funct3 = 0;
  logic mem_req_valid, mem_req_ready = 0, mem_req_wen, mem_resp_valid = 0;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = 0, out_data;
  logic [3:0] mem_req_wstrb;
  logic out_valid, out_ready = 0, out_misalign;
  int n_cmp = 0, n_err = 0;
  bit started = 0, busy = 0;
  bit exp_req, exp_wen, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic [3:0] exp_wstrb;
  logic [31:0] got_addr, got_wdata, got_data;
  logic [3:0] got_wstrb;
  logic got_wen, got_mis;

  ysyx_23060191_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_wdata(in_wdata), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic longint m_size(input logic [2:0] f);
    return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input longint off, input logic [2:0] f);
    longint s = m_size(f);
    longint v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * s));
    if (f[2] == 1'b0 && s < 4 && v >= (longint'(1) << (8 * s - 1))) v -= longint'(1) << (8 * s);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_swdata(input logic [31:0] wd, input logic [2:0] f);
    longint s = m_size(f);
    longint u = longint'(wd) % (longint'(1) << (8 * s));
    longint r = 0;
    for (int k = 0; k < 4 / s; k++) r += u << (8 * s * k);
    return 32'(r);
  endfunction

  always @(negedge clk) if (started && rst_n) begin
    chk("in_ready", in_ready, !busy);
    if (!busy || !exp_req) chk("no_req", mem_req_valid, 0);
    else if (mem_req_valid) begin
      chk("req_wen", mem_req_wen, exp_wen);
      chk("req_addr", mem_req_addr, exp_addr);
      chk("req_wstrb", mem_req_wstrb, exp_wstrb);
      if (exp_wen) chk("req_wdata", mem_req_wdata, exp_wdata);
    end
    if (!busy) chk("stray_out", out_valid, 0);
    else if (out_valid) begin
      chk("out_data", out_data, exp_data);
      chk("out_misalign", out_misalign, exp_mis);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // op: 0 non-mem, 1 load, 2 store, 3 both flags (behaves as load)
  task automatic run(input int op, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [2:0] f, input int rq_wait, input bit same, input int rs_wait, input int o_wait);
    longint s = m_size(f);
    longint off = longint'(a) % 4;
    exp_mis   = op != 0 && (longint'(a) % s) != 0;
    exp_req   = op != 0 && !exp_mis;
    exp_wen   = op == 2;
    exp_addr  = a - 32'(off);
    exp_wdata = m_swdata(wd, f);
    exp_wstrb = exp_wen ? 4'(((longint'(1) << s) - 1) << off) : 4'b0;
    exp_data  = op == 0 ? a : (exp_mis || op == 2) ? 32'h0 : m_load(rd, off, f);
    in_valid = 1; in_alu_result = a; in_wdata = wd; in_funct3 = f;
    in_is_load = op == 1 || op == 3; in_is_store = op == 2 || op == 3;
    step();
    busy = 1;
    in_valid = 0; in_alu_result = 32'hFFFF_FFFF; in_wdata = ~wd; in_is_load = 0; in_is_store = 0;
    if (exp_req) begin
      chk("req_latency", mem_req_valid, 1);
      got_addr = mem_req_addr; got_wdata = mem_req_wdata; got_wstrb = mem_req_wstrb; got_wen = mem_req_wen;
      repeat (rq_wait) step();
      mem_req_ready = 1;
      if (same) begin mem_resp_valid = 1; mem_resp_rdata = rd; end
      step();
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 32'h5A5A_5A5A;
      if (!same) begin
        repeat (rs_wait) begin chk("early_out", out_valid, 0); step(); end
        mem_resp_valid = 1; mem_resp_rdata = rd;
        step();
        mem_resp_valid = 0; mem_resp_rdata = 32'h5A5A_5A5A;
      end
    end
    chk("out_latency", out_valid, 1);
    got_data = out_data; got_mis = out_misalign;
    repeat (o_wait) step();
    out_ready = 1;
    step();
    out_ready = 0;
    busy = 0;
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_wen", mem_req_wen, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wdata", mem_req_wdata, 0);
    chk("rst_req_wstrb", mem_req_wstrb, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_misalign", out_misalign, 0);
  endtask

  initial begin
    step(); step();
    rst_n = 1;
    started = 1;
    chk_reset();
    run(0, 32'h1234_5678, 0, 0, 3'b000, 0, 0, 0, 0);
    chk("lit_nonmem", got_data, 32'h1234_5678);
    run(1, 32'h8000_0003, 0, 32'h80FF_0000, 3'b000, 0, 0, 1, 0);
    chk("lit_lb_addr", got_addr, 32'h8000_0000);
    chk("lit_lb_wstrb", got_wstrb, 4'b0000);
    chk("lit_lb", got_data, 32'hFFFF_FF80);
    run(1, 32'h8000_0003, 0, 32'h80FF_0000, 3'b100, 0, 0, 0, 0);
    chk("lit_lbu", got_data, 32'h0000_0080);
    run(2, 32'h8000_0002, 32'hDEAD_BEEF, 0, 3'b001, 0, 0, 1, 0);
    chk("lit_sh_wen", got_wen, 1);
    chk("lit_sh_wstrb", got_wstrb, 4'b1100);
    chk("lit_sh_wdata", got_wdata, 32'hBEEF_BEEF);
    chk("lit_sh_out", got_data, 0);
    run(1, 32'h8000_0001, 0, 0, 3'b010, 0, 0, 0, 0);
    chk("lit_lw_mis", got_mis, 1);
    chk("lit_lw_mis_data", got_data, 0);
    run(1, 32'h8000_0102, 0, 32'h8765_4321, 3'b001, 3, 0, 1, 2);
    chk("lit_lh_bp", got_data, 32'hFFFF_8765);
    run(1, 32'h8000_0010, 0, 32'hCAFE_F00D, 3'b010, 1, 1, 0, 0);
    chk("lit_lw_same", got_data, 32'hCAFE_F00D);
    run(2, 32'h8000_0041, 32'h1122_3344, 0, 3'b000, 0, 0, 0, 1);
    chk("lit_sb_wstrb", got_wstrb, 4'b0010);
    chk("lit_sb_wdata", got_wdata, 32'h4444_4444);
    run(1, 32'h8000_0042, 0, 32'h8765_4321, 3'b101, 0, 0, 2, 0);
    chk("lit_lhu", got_data, 32'h0000_8765);
    run(1, 32'h8000_0050, 0, 32'h1357_9BDF, 3'b110, 0, 0, 0, 0);
    run(3, 32'h8000_0061, 32'hFFFF_FFFF, 32'h0000_A500, 3'b000, 0, 0, 0, 0);
    chk("lit_both_lb", got_data, 32'hFFFF_FFA5);
    run(2, 32'h8000_0073, 32'h0000_ABCD, 0, 3'b001, 0, 0, 0, 0);
    run(2, 32'h8000_0080, 32'hCAFE_BABE, 0, 3'b010, 2, 0, 2, 0);
    chk("lit_sw_wstrb", got_wstrb, 4'b1111);
    exp_mis = 0; exp_req = 1; exp_wen = 0; exp_addr = 32'h8000_0020; exp_wstrb = 0; exp_data = 0;
    in_valid = 1; in_alu_result = 32'h8000_0020; in_funct3 = 3'b010; in_is_load = 1;
    step();
    busy = 1; in_valid = 0; in_is_load = 0;
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    step();
    rst_n = 0;
    step();
    rst_n = 1; busy = 0;
    chk_reset();
    mem_resp_valid = 1; mem_resp_rdata = 32'h7777_7777;
    step();
    mem_resp_valid = 0;
    chk("stray_resp_out", out_valid, 0);
    step();
    chk("stray_resp_out2", out_valid, 0);
    chk("stray_resp_ready", in_ready, 1);
    run(0, 32'h0BAD_F00D, 0, 0, 3'b010, 0, 0, 0, 0);
    chk("lit_after_rst", got_data, 32'h0BAD_F00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_23060191_lsu.md
Name: ysyx_23060191_lsu

Overview:
Load/store unit directly downstream of the integer ALU in the ysyx_23060191 core. It accepts the ALU result as the effective address, plus the store data and access type. It runs one word-aligned request/response transaction on a simple memory port, aligns and extends load data, and hands one result per instruction to write-back. Non-memory instructions pass the ALU result through with one cycle of latency.

Parameters:
XLEN, 32, datapath and address width (matches CPU_WIDTH)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset, sampled on rising clk
in_valid  in  1  upstream (EXU) holds a valid instruction
in_ready  out  1  LSU can accept; high only in IDLE
in_alu_result  in  XLEN  ALU result; effective address for memory ops
in_wdata  in  XLEN  store data (rs2)
in_is_load  in  1  instruction is a load
in_is_store  in  1  instruction is a store; is_load and is_store both high is illegal and treated as load
in_funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  1 = write
mem_req_addr  out  XLEN  address with bits [1:0] = 0
mem_req_wdata  out  XLEN  store data shifted to byte lane
mem_req_wstrb  out  4  byte-lane write enables; 0 on reads
mem_resp_valid  in  1  response valid, one cycle pulse; reads and writes both respond
mem_resp_rdata  in  XLEN  read word
out_valid  out  1  result valid to write-back
out_ready  in  1  write-back accepts result
out_data  out  XLEN  load data (extended), ALU result (non-mem), or 0 (store)
out_misalign  out  1  access was misaligned; no memory access was made

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. in_ready=1. mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0. out_valid=0, out_data=0, out_misalign=0. Reset mid-transaction abandons it; a later stray mem_resp_valid in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: an accept (in_valid & in_ready) latches address, wdata, funct3, op type and misalign flag.
  - Non-mem, or misaligned mem -> DONE.
  - Aligned mem -> REQ.
- REQ: mem_req_valid=1 with stable fields until mem_req_ready. The handshake moves REQ -> WAIT. If mem_resp_valid arrives in the same cycle as the handshake, go straight to DONE and capture the response.
- WAIT: mem_resp_valid -> DONE, capturing rdata. No timeout.
- DONE: out_valid=1 with out_data/out_misalign held stable until out_ready. The handshake returns the FSM to IDLE. The next instruction is accepted no earlier than the following cycle (no bypass).
- Non-mem latency: accept cycle N, out_valid at N+1. Aligned mem latency: mem_req_valid at N+1; out_valid one cycle after mem_resp_valid.
- Misalignment:
  - H/HU: addr[0]=1 is misaligned.
  - W: addr[1:0]≠0 is misaligned.
  - B/BU: never misaligned.
  - Misaligned access: out_misalign=1, out_data=0, no memory request.
- Store lanes, with off=addr[1:0]:
  - B: wstrb=0001<<off, wdata=(wdata[7:0] replicated to all 4 bytes).
  - H: wstrb=0011<<off, wdata=(wdata[15:0] replicated twice).
  - W: wstrb=1111, wdata=wdata.
- Load extraction: byte = rdata >> (8*off).
  - B: sign-extend bits [7:0]. BU: zero-extend [7:0].
  - H: sign-extend [15:0]. HU: zero-extend [15:0].
  - W: full word.
  - funct3 011/110/111: treated as W.
- Store result: out_data=0 and out_valid is still produced, after mem_resp_valid.
- in_ready=(state==IDLE). Upstream inputs are ignored outside IDLE.

Test Plan:
- Non-mem pass-through: in_alu_result=0x1234_5678, no mem flags, out_ready=1 -> out_valid 1 cycle after accept, out_data=0x12345678, no mem_req_valid.
- LB sign-extend: addr=0x8000_0003, mem_resp_rdata=0x80FF_0000, funct3=000 -> mem_req_addr=0x80000000, wstrb=0, out_data=0xFFFF_FF80. Same with funct3=100 -> 0x0000_0080.
- SH lane: addr=0x8000_0002, wdata=0xDEAD_BEEF, funct3=001 -> wen=1, wstrb=1100, wdata=0xBEEF_BEEF, out_data=0 after response.
- Misaligned LW: addr=0x8000_0001, funct3=010 -> no request, out_valid next cycle, out_misalign=1, out_data=0.
- Backpressure:
  - Hold mem_req_ready=0 for 3 cycles, then out_ready=0 for 2 cycles -> request fields and out_data stable throughout; in_ready=0 until the out handshake.
  - Then deliver mem_resp_valid in the same cycle as the request handshake -> DONE is reached directly.
- Reset mid-WAIT: drop rst_n for 1 cycle in WAIT -> all outputs at reset values next cycle; a subsequent mem_resp_valid produces no out_valid.
